// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit framer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int BITS_PER_BYTE = 8;
  localparam int BIT_IDX_W = $clog2(BITS_PER_BYTE);

  function automatic int cnt_width(int clks);
    return (clks < 2) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/uart_tx_parity.sv
// Parity bit generator: even parity when odd_i=0, odd parity when odd_i=1.
module uart_tx_parity
  import uart_pkg::*;
(
  input  logic [BITS_PER_BYTE-1:0] data_i,
  input  logic                     odd_i,
  output logic                     parity_o
);

  assign parity_o = (^data_i) ^ odd_i;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, 8 data bits LSB first, optional parity, stop.
// Parity bit is present only when UART_TX_PARITY_EN is defined.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [BITS_PER_BYTE-1:0] tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  input  logic                     parity_sel,
  output logic                     tx_serial,
  output logic                     tx_busy,
  output logic                     tx_done
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] DATA_LAST = BIT_IDX_W'(BITS_PER_BYTE - 1);
  localparam logic [BIT_IDX_W-1:0] STOP_LAST = BIT_IDX_W'(STOP_BITS - 1);

  tx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0] idx_q, idx_d;
  logic [BITS_PER_BYTE-1:0] shift_q, shift_d;
  logic par_q, par_d;
  logic serial_q, serial_d;
  logic ready_q, ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic accept, bit_end, par_bit;

  assign accept  = tx_valid && ready_q;
  assign bit_end = (cnt_q == CNT_LAST);

`ifdef UART_TX_PARITY_EN
  uart_tx_parity u_parity (
    .data_i  (tx_data),
    .odd_i   (parity_sel),
    .parity_o(par_bit)
  );
`else
  logic unused_parity_sel;
  assign unused_parity_sel = parity_sel;
  assign par_bit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (accept) begin
          state_d = START;
          shift_d = tx_data;
          par_d   = par_bit;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == DATA_LAST) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) state_d = IDLE;
          else idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered.
  always_comb begin
    serial_d = 1'b1;
    unique case (state_d)
      IDLE:    serial_d = 1'b1;
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
      PARITY:  serial_d = par_d;
      STOP:    serial_d = 1'b1;
      default: serial_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == STOP) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      serial_q <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx_serial = serial_q;
  assign tx_ready  = ready_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: frame-level model checked every cycle plus a line receiver.
`timescale 1ns/1ps
module tb_uart_tx_frame;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
  localparam int S = 1;
`else
  localparam int P = 0;
  localparam int S = 2;
`endif
  localparam int NB = 1 + 8 + P + S;
  localparam int NC = NB * C;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic parity_sel = 1'b0;
  logic tx_ready, tx_serial, tx_busy, tx_done;

  int checks = 0;
  int passed = 0;

  uart_tx_frame #(
    .CLKS_PER_BIT(C),
    .STOP_BITS   (S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .parity_sel(parity_sel),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Frame model: remaining cycles of the frame in flight and its bit list.
  int rem = 0;
  int acc = 0;
  int cyc = 0;
  int hs_cyc = 0;
  logic mdone = 1'b0;
  logic [7:0] fbyte = 8'h00;
  logic fpar = 1'b0;

  function automatic logic fbit(int i, logic [7:0] b, logic p);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (P == 1 && i == 9) return p;
    return 1'b1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= 0;
      mdone <= 1'b0;
    end else begin
      mdone <= 1'b0;
      if (rem > 0) begin
        rem <= rem - 1;
        if (rem == 1) mdone <= 1'b1;
      end else if (tx_valid) begin
        rem    <= NC;
        fbyte  <= tx_data;
        fpar   <= (^tx_data) ^ parity_sel;
        acc    <= acc + 1;
        hs_cyc <= cyc + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("serial", tx_serial,
          (rem == 0) ? 1'b1 : fbit((NC - rem) / C, fbyte, fpar));
    check("ready", tx_ready, rem == 0);
    check("busy", tx_busy, rem != 0);
    check("done", tx_done, mdone);
  end

  task automatic send(logic [7:0] b, logic ps);
    int a0;
    int n;
    a0 = acc;
    n = 0;
    tx_data = b;
    parity_sel = ps;
    tx_valid = 1'b1;
    while (acc == a0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("accept_busy", tx_busy, 1'b1);
    tx_valid = 1'b0;
  endtask

  task automatic rx_frame(output logic [7:0] d, output logic p, output int st);
    int n;
    n = 0;
    d = 8'h00;
    p = 1'b0;
    while (tx_serial !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    st = cyc;
    check("rx_start", tx_serial, 1'b0);
    repeat (C / 2) @(negedge clk);
    check("rx_start_mid", tx_serial, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (C) @(negedge clk);
      d[i] = tx_serial;
    end
    if (P == 1) begin
      repeat (C) @(negedge clk);
      p = tx_serial;
    end
    for (int i = 0; i < S; i++) begin
      repeat (C) @(negedge clk);
      check("rx_stop", tx_serial, 1'b1);
    end
  endtask

  task automatic wait_done(string name);
    int n;
    n = 0;
    while (tx_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, cyc - hs_cyc, 44);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d1, d2;
    logic p1, p2;
    int s1, s2;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_serial", tx_serial, 1'b1);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame and end-of-frame timing
    send(8'h55, 1'b0);
    rx_frame(d1, p1, s1);
    check("t1_data", d1, 8'h55);
`ifdef UART_TX_PARITY_EN
    check("t1_par", p1, 1'b0);
`endif
    wait_done("t1_done_lat");
    repeat (3) @(negedge clk);

`ifdef UART_TX_PARITY_EN
    send(8'h07, 1'b1);
    rx_frame(d1, p1, s1);
    check("t2_data_odd", d1, 8'h07);
    check("t2_par_odd", p1, 1'b0);
    repeat (3) @(negedge clk);
    send(8'h07, 1'b0);
    rx_frame(d1, p1, s1);
    check("t2_par_even", p1, 1'b1);
    repeat (3) @(negedge clk);
`else
    send(8'hF0, 1'b0);
    rx_frame(d1, p1, s1);
    check("t6_data", d1, 8'hF0);
    wait_done("t6_done_lat");
    repeat (3) @(negedge clk);
`endif

    // Back-to-back with tx_valid held high
    fork
      begin
        int a0;
        int n;
        a0 = acc;
        n = 0;
        tx_data = 8'hA5;
        parity_sel = 1'b0;
        tx_valid = 1'b1;
        while (acc == a0 && n < 300) begin
          @(negedge clk);
          n++;
        end
        tx_data = 8'h3C;
        n = 0;
        while (acc == a0 + 1 && n < 300) begin
          @(negedge clk);
          n++;
        end
        tx_valid = 1'b0;
      end
      begin
        rx_frame(d1, p1, s1);
        rx_frame(d2, p2, s2);
      end
    join
    check("t3_byte1", d1, 8'hA5);
    check("t3_byte2", d2, 8'h3C);
    check("t3_gap", s2 - s1, NC + 1);
`ifdef UART_TX_PARITY_EN
    check("t3_par1", p1, 1'b0);
    check("t3_par2", p2, 1'b0);
`endif
    repeat (NC + 4) @(negedge clk);

    // Inputs changed while the frame is in flight
    send(8'h12, 1'b0);
    fork
      rx_frame(d1, p1, s1);
      begin
        repeat (3 * C) @(negedge clk);
        tx_data = 8'hFF;
        parity_sel = 1'b1;
      end
    join
    check("t4_data", d1, 8'h12);
`ifdef UART_TX_PARITY_EN
    check("t4_par", p1, 1'b0);
`endif
    repeat (4) @(negedge clk);

    // Asynchronous reset during data bit 3
    send(8'hC3, 1'b0);
    repeat (4 * C + 1) @(negedge clk);
    check("t5_pre_serial", tx_serial, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("t5_serial", tx_serial, 1'b1);
    check("t5_ready", tx_ready, 1'b1);
    check("t5_busy", tx_busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(8'h81, 1'b0);
    rx_frame(d1, p1, s1);
    check("t5_data", d1, 8'h81);
`ifdef UART_TX_PARITY_EN
    check("t5_par", p1, 1'b0);
`endif
    repeat (8) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmit framer. Accepts one 8-bit byte per valid/ready handshake and serialises it onto a single line.
- Frame order: start bit (0), data bits LSB first, optional parity bit, stop bit(s) (1).
- Bit timing comes from an internal baud divider.
- Sits downstream of the host byte source and drives the TX pin directly.

Parameters:
CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); legal range 2..65535
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
tx_data  input  8  byte to transmit
tx_valid  input  1  tx_data is valid
tx_ready  output  1  block can accept a byte this cycle
parity_sel  input  1  0 = even parity, 1 = odd parity; sampled at handshake
tx_serial  output  1  serial line, idle high
tx_busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at end of frame

Behaviour:
- Clocking and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values: tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, baud counter=0, bit index=0.
- Reset mid-frame: the line returns high immediately (async). The partial frame is abandoned and is not resumed.
- Handshake: the byte is accepted on a rising edge where tx_valid && tx_ready.
  - tx_data and parity_sel are latched into internal registers at that edge.
  - Later changes on either input have no effect on the frame in flight.
- tx_ready = 1 only in IDLE. tx_ready is registered; there is no combinational path from tx_valid.
- tx_valid while not ready: ignored, no side effects.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: tx_serial=1. On handshake -> START.
  - START: tx_serial=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: tx_serial=shift_reg[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit index 7 -> PARITY (feature on) or STOP (feature off).
  - PARITY: tx_serial = (XOR of latched byte) XOR latched parity_sel, for CLKS_PER_BIT cycles -> STOP.
  - STOP: tx_serial=1 for STOP_BITS*CLKS_PER_BIT cycles -> IDLE.
- Registered outputs:
  - tx_serial is a flop output, glitch-free.
  - The first start-bit cycle is the cycle immediately after the handshake edge.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Width = $clog2(CLKS_PER_BIT).
  - Cleared in IDLE.
- tx_busy = 1 in every non-IDLE state.
- tx_done:
  - Asserted for exactly one cycle: the first IDLE cycle after STOP completes.
  - tx_ready is also 1 in that cycle.
  - A handshake in that cycle is legal (back-to-back). The next start bit begins one cycle later, so the minimum idle-high gap between frames is 1 cycle.
- Frame occupancy, handshake edge to tx_ready=1: (1 + 8 + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = 1 if parity is compiled in, else 0.

Optional Feature:
UART_TX_PARITY_EN
- Defined: the PARITY state exists and the frame carries a parity bit computed as above.
- Undefined: the PARITY state and parity logic are removed; DATA goes directly to STOP.
- parity_sel remains a port in both builds; it is ignored when the macro is undefined.

Decomposition:
- Package uart_pkg holds:
  - the state enum: IDLE, START, DATA, PARITY, STOP
  - BITS_PER_BYTE=8
  - localparam helpers for counter widths
- One sub-module, uart_tx_parity: purely combinational, 8-bit byte + parity_sel -> parity bit. It is instantiated only under UART_TX_PARITY_EN.
- The FSM, baud counter and shift register stay in uart_tx_frame.

Test Plan:
(All use CLKS_PER_BIT=4, STOP_BITS=1 unless stated.)
1. Parity on, byte 0x55, parity_sel=0 → line samples 0,1,0,1,0,1,0,1,0,0,1 (start, LSB-first data, parity 0, stop). Each level lasts 4 cycles. tx_done pulses 44 cycles after the handshake edge.
2. Parity on, byte 0x07, parity_sel=1 → parity bit = 1^1 = 0. With parity_sel=0 the parity bit = 1.
3. Back-to-back: tx_valid held high with 0xA5 then 0x3C → handshake in the tx_done cycle. The second start bit begins 1 cycle later. Both bytes are decoded correctly by the bench receiver.
4. Input stability: tx_data changed 0x12→0xFF and parity_sel toggled during DATA → transmitted frame still carries 0x12 and the original parity.
5. Reset mid-frame: assert rst_n=0 during DATA bit 3 → tx_serial=1 and tx_ready=1 immediately, with no clock edge needed. After release, byte 0x81 is sent correctly from a fresh start bit.
6. Parity off (macro undefined), STOP_BITS=2, byte 0xF0 → 11 bit periods total (44 cycles). No parity bit on the line. Stop level is held high for 8 cycles.
